// File: rtl/clk_div_pkg.sv
// clk_div_pkg: constants shared by the multi-channel clock divider
package clk_div_pkg;
    localparam int DEFAULT_HALF = 50000;
    localparam int MAX_NCH      = 8;
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with a shadowed half-period that swaps in only at a toggle or while idle
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 21,
    parameter int DEF_HALF = DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick
);
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);
    logic [CNT_W-1:0] cnt, act, shd, act_eff;
    logic             pend, tc;
    assign act_eff = (act == '0) ? CNT_W'(1) : act;
    assign tc      = en && (cnt == act_eff - CNT_W'(1));
    // a load in the same cycle as the swap must survive as the next pending value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            act     <= RST_HALF;
            shd     <= RST_HALF;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= (en && !tc) ? cnt + CNT_W'(1) : '0;
            clk_out <= en && (clk_out ^ tc);
            tick    <= tc;
            if (pend && (tc || !en)) begin
                act  <= shd;
                pend <= 1'b0;
            end
            if (load) begin
                shd  <= div_val;
                pend <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent 50% duty clock dividers sharing one input clock
module clk_div_multi
    import clk_div_pkg::MAX_NCH;
#(
    parameter int NCH          = 2,
    parameter int CNT_W        = 21,
    parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
    input  logic                 CLK_in,
    input  logic                 RST_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*CNT_W-1:0] div_val,
    output logic [NCH-1:0]       CLK_out,
    output logic [NCH-1:0]       tick
);
    if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
        $error("clk_div_multi: NCH out of range");
    end
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_HALF(DEFAULT_HALF)
        ) u_ch (
            .clk    (CLK_in),
            .rst_n  (RST_n),
            .en     (en[i]),
            .load   (load[i]),
            .div_val(div_val[i*CNT_W +: CNT_W]),
            .clk_out(CLK_out[i]),
            .tick   (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed stimulus, absolute-time reference model plus hand-computed literal checks
module tb_clk_div_multi;
    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int DH  = 4;

    logic                CLK_in  = 1'b0;
    logic                RST_n   = 1'b1;
    logic [NCH-1:0]      en      = '0;
    logic [NCH-1:0]      load    = '0;
    logic [NCH*CW-1:0]   div_val = '0;
    logic [NCH-1:0]      CLK_out;
    logic [NCH-1:0]      tick;
    int                  errors  = 0;
    int                  checks  = 0;

    clk_div_multi #(.NCH(NCH), .CNT_W(CW), .DEFAULT_HALF(DH)) dut (
        .CLK_in (CLK_in),
        .RST_n  (RST_n),
        .en     (en),
        .load   (load),
        .div_val(div_val),
        .CLK_out(CLK_out),
        .tick   (tick)
    );

    always #5 CLK_in = ~CLK_in;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK_in);
    endtask

    task automatic set_div(input int ch, input int v);
        div_val[ch*CW +: CW] = CW'(v);
    endtask

    // Reference model: each channel remembers the absolute edge number of its next toggle
    int cyc;
    int half[NCH], shd[NCH], next_t[NCH];
    bit pend[NCH], lvl[NCH], tk[NCH];

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    always begin
        @(posedge CLK_in);
        if (!RST_n) begin
            cyc = 0;
            for (int i = 0; i < NCH; i++) begin
                half[i] = DH; shd[i] = DH; next_t[i] = DH;
                pend[i] = 0; lvl[i] = 0; tk[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < NCH; i++) begin
                tk[i] = 0;
                if (en[i]) begin
                    if (cyc == next_t[i]) begin
                        tk[i]  = 1;
                        lvl[i] = !lvl[i];
                        if (pend[i]) begin half[i] = eff(shd[i]); pend[i] = 0; end
                        next_t[i] = cyc + half[i];
                    end
                end else begin
                    lvl[i] = 0;
                    if (pend[i]) begin half[i] = eff(shd[i]); pend[i] = 0; end
                    next_t[i] = cyc + half[i];
                end
                if (load[i]) begin
                    shd[i]  = int'(div_val[i*CW +: CW]);
                    pend[i] = 1;
                end
            end
        end
        #1;
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("model_clk_out[%0d]", i), int'(CLK_out[i]), int'(lvl[i]));
            check($sformatf("model_tick[%0d]", i), int'(tick[i]), int'(tk[i]));
        end
    end

    initial begin
        #1 RST_n = 1'b0;
        #1;
        check("reset_clk_out", int'(CLK_out), 0);
        check("reset_tick", int'(tick), 0);
        step(2);
        RST_n = 1'b1; en = 2'b11;
        step(3);
        check("pre_first_tick", int'(tick), 0);
        check("pre_first_clk", int'(CLK_out), 0);
        step(1);
        check("first_tick_edge4", int'(tick), 3);
        check("first_clk_edge4", int'(CLK_out), 3);
        step(4);
        check("tick_edge8", int'(tick), 3);
        check("clk_edge8", int'(CLK_out), 0);
        step(1);
        set_div(0, 2); load = 2'b01;
        step(1);
        load = 2'b00;
        step(4);
        check("shorter_half_ch0_only", int'(tick), 1);
        step(2);
        check("both_tick_edge16", int'(tick), 3);
        set_div(0, 0); load = 2'b01;
        step(1);
        load = 2'b00;
        step(3);
        check("zero_div_tick_edge20", int'(tick), 3);
        check("zero_div_clk_edge20", int'(CLK_out), 2);
        step(1);
        check("zero_div_tick_edge21", int'(tick), 1);
        check("zero_div_clk_edge21", int'(CLK_out), 3);
        step(2);
        set_div(0, 9); set_div(1, 6); load = 2'b10;
        step(1);
        load = 2'b00;
        check("load_at_tc_old_period", int'(tick), 3);
        check("load_at_tc_clk", int'(CLK_out), 0);
        step(4);
        check("tc_after_load_at_tc", int'(tick), 3);
        check("clk_edge28", int'(CLK_out), 2);
        step(5);
        check("no_tick_mid_six", int'(tick), 1);
        step(1);
        check("six_half_tick", int'(tick), 3);
        check("clk_edge34", int'(CLK_out), 0);
        step(7);
        en = 2'b01;
        step(1);
        check("en_drop_forces_low", int'({CLK_out[1], tick[1]}), 0);
        set_div(1, 2); load = 2'b10;
        step(1);
        load = 2'b00;
        step(1);
        en = 2'b11;
        step(1);
        check("restart_no_tick", int'(tick[1]), 0);
        step(1);
        check("restart_tick_after_act", int'({CLK_out[1], tick[1]}), 3);
        set_div(1, 7); load = 2'b10;
        step(1);
        load = 2'b00; RST_n = 1'b0;
        #1;
        check("async_reset_clk", int'(CLK_out), 0);
        check("async_reset_tick", int'(tick), 0);
        step(2);
        RST_n = 1'b1;
        step(3);
        check("post_reset_no_tick", int'(tick), 0);
        step(1);
        check("post_reset_tick_default", int'(tick), 3);
        check("post_reset_clk", int'(CLK_out), 3);
        step(4);
        check("pending_lost_tick", int'(tick), 3);
        check("pending_lost_clk", int'(CLK_out), 0);
        step(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
